i2cmb_wb_sequencer: RTL and testbench
=====================================

I2CMB_WB_SEQUENCER -- requirements
Module: i2cmb_wb_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum clk_i cycles to wait for irq_i per command.
REQ-002 SHALL have parameter CSR_INIT, default 8'hC0: value written to CSR after reset (E=1, IE=1).
REQ-003 SHALL have port clk_i, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid_i, input, 1: command offered.
REQ-006 SHALL have port cmd_ready_o, output, 1: sequencer accepts the command.
REQ-007 SHALL have port cmd_op_i, input, 3: opcode; 0 WAIT, 1 WRITE, 2 READ_ACK, 3 READ_NAK, 4 START, 5 STOP, 6 SET_BUS, 7 reserved.
REQ-008 SHALL have port cmd_data_i, input, 8: DPR payload (WRITE byte, WAIT ms, SET_BUS id).
REQ-009 SHALL have port rsp_valid_o, output, 1: response available.
REQ-010 SHALL have port rsp_ready_i, input, 1: consumer takes the response.
REQ-011 SHALL have port rsp_status_o, output, 3: 0 DON, 1 NAK, 2 AL, 3 ERR, 4 TIMEOUT, 5 BADOP.
REQ-012 SHALL have port rsp_data_o, output, 8: byte read; 0 for non-read ops.
REQ-013 SHALL have Wishbone master ports: cyc_o, stb_o, we_o (each 1, output); adr_o (2, output); dat_o (8, output); dat_i (8, input); ack_i (1, input); irq_i (1, input, DUT interrupt).

Function
REQ-014 FSM states SHALL be INIT_CSR, IDLE, WR_DPR, WR_CMDR, WAIT_IRQ, RD_CMDR, RD_DPR, RSP.
REQ-015 Each bus access SHALL be one Wishbone single cycle:
- cyc_o and stb_o are registered high on state entry.
- adr_o, we_o and dat_o are stable until ack_i is sampled.
- cyc_o and stb_o drop the following cycle.
- At least one idle cycle separates accesses.
REQ-016 INIT_CSR SHALL write CSR_INIT to adr 0, then go to IDLE; cmd_ready_o SHALL stay 0 until that write is acked.
REQ-017 cmd_ready_o SHALL be 1 only in IDLE; cmd_valid_i & cmd_ready_o SHALL capture op and data.
REQ-018 Command routing:
- Ops 0, 1, 6 SHALL go to WR_DPR (write adr 1 = data), then WR_CMDR.
- Ops 2–5 SHALL go directly to WR_CMDR.
- Op 7 SHALL go to RSP with BADOP and no bus access.
REQ-019 WR_CMDR SHALL write adr 2 with {5'b0, op}, then enter WAIT_IRQ with the timeout counter cleared.
REQ-020 WAIT_IRQ behaviour:
- irq_i high (level, sampled synchronously) SHALL move to RD_CMDR.
- Counter equal to TIMEOUT_CYCLES SHALL move to RSP with TIMEOUT and no CMDR read.
- irq_i takes priority over timeout when both occur in the same cycle.
REQ-021 Timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1); it SHALL saturate and never wrap.
REQ-022 RD_CMDR SHALL read adr 2 and decode status with priority ERR(bit4) > AL(bit5) > NAK(bit6) > DON(bit7); if no bit is set, status SHALL be ERR.
REQ-023 A READ_ACK or READ_NAK op with DON status SHALL then read adr 1 (RD_DPR) into rsp_data_o; all other cases SHALL go to RSP.
REQ-024 In RSP, rsp_valid_o SHALL hold, and rsp_status_o and rsp_data_o SHALL stay stable, until rsp_ready_i; the next cycle SHALL be IDLE.
REQ-025 Ignored inputs:
- ack_i outside an active access SHALL be ignored.
- irq_i outside WAIT_IRQ SHALL be ignored.

Reset
REQ-026 On rst_i, all outputs (cyc_o, stb_o, we_o, adr_o, dat_o, cmd_ready_o, rsp_valid_o, rsp_status_o, rsp_data_o) SHALL be 0 immediately, the state SHALL be INIT_CSR and the counter 0.
REQ-027 Reset mid-operation SHALL abort the bus cycle and discard the in-flight command with no response; the CSR write SHALL repeat after release.

Structure
REQ-028 The opcode enum, status enum, register addresses (CSR=0, DPR=1, CMDR=2, FSMR=3) and CMDR bit positions SHALL live in the shared package i2cmb_seq_pkg.
REQ-029 The Wishbone single-access handshake SHALL be one sub-module, i2cmb_wb_master_port (req/addr/we/wdata in; done/rdata out).

Verification
REQ-030 Reset release -> first access writes adr 0 with 8'hC0; cmd_ready_o is 0 until its ack.
REQ-031 START, irq, CMDR=8'h80 -> write adr 2 = 8'h04, read adr 2; response DON, data 8'h00.
REQ-032 WRITE 8'hA5, irq, CMDR=8'h40 -> write adr 1 = 8'hA5, write adr 2 = 8'h01; response NAK.
REQ-033 READ_ACK, irq, CMDR=8'h80, DPR=8'h3C -> write adr 2 = 8'h02, read adr 2, read adr 1; response DON, data 8'h3C.
REQ-034 TIMEOUT_CYCLES=16, no irq -> TIMEOUT response after 16 cycles in WAIT_IRQ, no CMDR read; the next command is accepted.
REQ-035 rst_i during WR_DPR with stb_o high -> cyc_o and stb_o go 0 asynchronously, no response, CSR write repeats after release.

Source files
------------

// File: rtl/i2cmb_seq_pkg.sv
// Shared opcode/status encodings, I2CMB register map and CMDR bit layout
// used by the Wishbone command sequencer.
package i2cmb_seq_pkg;

   typedef enum logic [2:0] {
      OP_WAIT     = 3'd0,
      OP_WRITE    = 3'd1,
      OP_READ_ACK = 3'd2,
      OP_READ_NAK = 3'd3,
      OP_START    = 3'd4,
      OP_STOP     = 3'd5,
      OP_SET_BUS  = 3'd6,
      OP_RSVD     = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      ST_DON     = 3'd0,
      ST_NAK     = 3'd1,
      ST_AL      = 3'd2,
      ST_ERR     = 3'd3,
      ST_TIMEOUT = 3'd4,
      ST_BADOP   = 3'd5
   } status_e;

   typedef enum logic [2:0] {
      S_INIT_CSR, S_IDLE, S_WR_DPR, S_WR_CMDR,
      S_WAIT_IRQ, S_RD_CMDR, S_RD_DPR, S_RSP
   } state_e;

   localparam logic [1:0] ADR_CSR  = 2'd0;
   localparam logic [1:0] ADR_DPR  = 2'd1;
   localparam logic [1:0] ADR_CMDR = 2'd2;
   localparam logic [1:0] ADR_FSMR = 2'd3;

   localparam int CMDR_ERR = 4;
   localparam int CMDR_AL  = 5;
   localparam int CMDR_NAK = 6;
   localparam int CMDR_DON = 7;

   // Error outranks arbitration loss, which outranks NAK; an empty status reads as error.
   function automatic status_e decode_cmdr(input logic [7:0] c);
      if (c[CMDR_ERR])      return ST_ERR;
      else if (c[CMDR_AL])  return ST_AL;
      else if (c[CMDR_NAK]) return ST_NAK;
      else if (c[CMDR_DON]) return ST_DON;
      else                  return ST_ERR;
   endfunction

   function automatic logic op_has_dpr(input op_e op);
      return (op == OP_WAIT) || (op == OP_WRITE) || (op == OP_SET_BUS);
   endfunction

   function automatic logic op_is_read(input op_e op);
      return (op == OP_READ_ACK) || (op == OP_READ_NAK);
   endfunction

endpackage

// File: rtl/i2cmb_wb_master_port.sv
// One Wishbone single-cycle access per request; done pulses one cycle after
// the ack edge, which guarantees an idle bus cycle between back-to-back accesses.
module i2cmb_wb_master_port (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       i_req,
   input  logic [1:0] i_addr,
   input  logic       i_we,
   input  logic [7:0] i_wdata,
   output logic       o_done,
   output logic [7:0] o_rdata,
   output logic       o_cyc,
   output logic       o_stb,
   output logic       o_we,
   output logic [1:0] o_adr,
   output logic [7:0] o_dat,
   input  logic [7:0] i_dat,
   input  logic       i_ack
);

   logic       r_cyc;
   logic       r_we;
   logic [1:0] r_adr;
   logic [7:0] r_dat;
   logic       r_done;
   logic [7:0] r_rdata;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cyc   <= 1'b0;
         r_we    <= 1'b0;
         r_adr   <= 2'd0;
         r_dat   <= 8'd0;
         r_done  <= 1'b0;
         r_rdata <= 8'd0;
      end else begin
         r_done <= 1'b0;
         if (r_cyc) begin
            // ack is only honoured while a cycle is open
            if (i_ack) begin
               r_cyc   <= 1'b0;
               r_we    <= 1'b0;
               r_dat   <= 8'd0;
               r_done  <= 1'b1;
               r_rdata <= i_dat;
            end
         end else if (i_req) begin
            r_cyc <= 1'b1;
            r_adr <= i_addr;
            r_we  <= i_we;
            r_dat <= i_we ? i_wdata : 8'd0;
         end
      end
   end

   assign o_cyc   = r_cyc;
   assign o_stb   = r_cyc;
   assign o_we    = r_we;
   assign o_adr   = r_adr;
   assign o_dat   = r_dat;
   assign o_done  = r_done;
   assign o_rdata = r_rdata;

endmodule

// File: rtl/i2cmb_wb_sequencer.sv
// Turns one command/response transaction into the I2CMB DPR/CMDR Wishbone
// access sequence, waiting on the core interrupt with a bounded timeout.
module i2cmb_wb_sequencer
   import i2cmb_seq_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 65535,
   parameter logic [7:0]  CSR_INIT       = 8'hC0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [2:0] cmd_op_i,
   input  logic [7:0] cmd_data_i,
   output logic       rsp_valid_o,
   input  logic       rsp_ready_i,
   output logic [2:0] rsp_status_o,
   output logic [7:0] rsp_data_o,
   output logic       cyc_o,
   output logic       stb_o,
   output logic       we_o,
   output logic [1:0] adr_o,
   output logic [7:0] dat_o,
   input  logic [7:0] dat_i,
   input  logic       ack_i,
   input  logic       irq_i
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   state_e           r_state, w_nxt;
   op_e              r_op, w_op;
   status_e          r_status, w_status;
   logic [7:0]       r_data, w_data;
   logic [7:0]       r_rdata, w_rdata;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic             r_init_pend;

   logic             w_req, w_req_we, w_done;
   logic [1:0]       w_req_adr;
   logic [7:0]       w_req_dat, w_bus_rdata;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_INIT_CSR;
         r_op        <= OP_WAIT;
         r_status    <= ST_DON;
         r_data      <= 8'd0;
         r_rdata     <= 8'd0;
         r_cnt       <= '0;
         r_init_pend <= 1'b1;
      end else begin
         r_state     <= w_nxt;
         r_op        <= w_op;
         r_status    <= w_status;
         r_data      <= w_data;
         r_rdata     <= w_rdata;
         r_cnt       <= w_cnt;
         r_init_pend <= 1'b0;
      end
   end

   always_comb begin
      w_nxt    = r_state;
      w_op     = r_op;
      w_status = r_status;
      w_data   = r_data;
      w_rdata  = r_rdata;
      w_cnt    = r_cnt;
      case (r_state)
         S_INIT_CSR: if (w_done) w_nxt = S_IDLE;
         S_IDLE: begin
            if (cmd_valid_i) begin
               w_op     = op_e'(cmd_op_i);
               w_data   = cmd_data_i;
               w_rdata  = 8'd0;
               w_status = ST_DON;
               if (w_op == OP_RSVD) begin
                  w_status = ST_BADOP;
                  w_nxt    = S_RSP;
               end else if (op_has_dpr(w_op)) begin
                  w_nxt = S_WR_DPR;
               end else begin
                  w_nxt = S_WR_CMDR;
               end
            end
         end
         S_WR_DPR: if (w_done) w_nxt = S_WR_CMDR;
         S_WR_CMDR: begin
            if (w_done) begin
               w_nxt = S_WAIT_IRQ;
               w_cnt = '0;
            end
         end
         S_WAIT_IRQ: begin
            // irq wins over a timeout landing in the same cycle
            if (irq_i) begin
               w_nxt = S_RD_CMDR;
            end else if (r_cnt == CNT_MAX) begin
               w_nxt    = S_RSP;
               w_status = ST_TIMEOUT;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         S_RD_CMDR: begin
            if (w_done) begin
               w_status = decode_cmdr(w_bus_rdata);
               w_nxt    = (op_is_read(r_op) && w_status == ST_DON) ? S_RD_DPR : S_RSP;
            end
         end
         S_RD_DPR: begin
            if (w_done) begin
               w_rdata = w_bus_rdata;
               w_nxt   = S_RSP;
            end
         end
         S_RSP: if (rsp_ready_i) w_nxt = S_IDLE;
         default: w_nxt = S_INIT_CSR;
      endcase
   end

   // Launch an access on the same edge that enters an access state, so cyc is high on entry.
   always_comb begin
      w_req     = r_init_pend ||
                  ((w_nxt != r_state) && (w_nxt inside {S_WR_DPR, S_WR_CMDR, S_RD_CMDR, S_RD_DPR}));
      w_req_adr = ADR_CSR;
      w_req_we  = 1'b1;
      w_req_dat = CSR_INIT;
      case (w_nxt)
         S_WR_DPR:  begin w_req_adr = ADR_DPR;  w_req_we = 1'b1; w_req_dat = w_data;        end
         S_WR_CMDR: begin w_req_adr = ADR_CMDR; w_req_we = 1'b1; w_req_dat = {5'b0, w_op}; end
         S_RD_CMDR: begin w_req_adr = ADR_CMDR; w_req_we = 1'b0; w_req_dat = 8'd0;          end
         S_RD_DPR:  begin w_req_adr = ADR_DPR;  w_req_we = 1'b0; w_req_dat = 8'd0;          end
         default: ;
      endcase
   end

   i2cmb_wb_master_port u_port (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_req   (w_req),
      .i_addr  (w_req_adr),
      .i_we    (w_req_we),
      .i_wdata (w_req_dat),
      .o_done  (w_done),
      .o_rdata (w_bus_rdata),
      .o_cyc   (cyc_o),
      .o_stb   (stb_o),
      .o_we    (we_o),
      .o_adr   (adr_o),
      .o_dat   (dat_o),
      .i_dat   (dat_i),
      .i_ack   (ack_i)
   );

   assign cmd_ready_o  = (r_state == S_IDLE);
   assign rsp_valid_o  = (r_state == S_RSP);
   assign rsp_status_o = r_status;
   assign rsp_data_o   = r_rdata;

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Directed bench: a spec-level model predicts the Wishbone access list and
// response of each command; a per-cycle monitor checks the DUT against it.
module tb_i2cmb_wb_sequencer;

   localparam int TO = 16;
   localparam logic [2:0] S_DON = 3'd0, S_NAK = 3'd1, S_AL = 3'd2,
                          S_ERR = 3'd3, S_TO = 3'd4, S_BAD = 3'd5;

   logic       clk = 1'b0, rst = 1'b1;
   logic       cmd_valid = 1'b0, cmd_ready;
   logic [2:0] cmd_op = 3'd0;
   logic [7:0] cmd_data = 8'd0;
   logic       rsp_valid, rsp_ready = 1'b0;
   logic [2:0] rsp_status;
   logic [7:0] rsp_data;
   logic       cyc_o, stb_o, we_o;
   logic [1:0] adr_o;
   logic [7:0] dat_o;
   logic [7:0] dat_i;
   logic       ack_i, irq_i;

   typedef struct packed { logic [1:0] adr; logic we; logic [7:0] dat; } acc_t;
   acc_t exp_q[$];

   int n_cmp = 0, n_fail = 0;
   int cyc_ctr = 0, last_fall = 0;
   logic       exp_rsp_on = 1'b0;
   logic [2:0] exp_st = 3'd0;
   logic [7:0] exp_rd = 8'd0;
   logic [7:0] cur_cmdr = 8'd0, cur_dpr = 8'd0;
   logic       irq_en = 1'b0;
   int         spur_req = 0;

   i2cmb_wb_sequencer #(.TIMEOUT_CYCLES(TO), .CSR_INIT(8'hC0)) dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_op_i(cmd_op), .cmd_data_i(cmd_data),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_status_o(rsp_status), .rsp_data_o(rsp_data),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
      .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Spec-level prediction of the bus access list and response for one command.
   task automatic model(input logic [2:0] op, input logic [7:0] d, input logic [7:0] cmdr,
                        input logic [7:0] dpr, input logic irq,
                        output logic [2:0] st, output logic [7:0] rd);
      rd = 8'h00;
      if (op == 3'd7) begin st = S_BAD; return; end
      if (op == 3'd0 || op == 3'd1 || op == 3'd6) exp_q.push_back('{2'd1, 1'b1, d});
      exp_q.push_back('{2'd2, 1'b1, {5'b0, op}});
      if (!irq) begin st = S_TO; return; end
      exp_q.push_back('{2'd2, 1'b0, 8'h00});
      if (cmdr[4])      st = S_ERR;
      else if (cmdr[5]) st = S_AL;
      else if (cmdr[6]) st = S_NAK;
      else if (cmdr[7]) st = S_DON;
      else              st = S_ERR;
      if ((op == 3'd2 || op == 3'd3) && st == S_DON) begin
         exp_q.push_back('{2'd1, 1'b0, 8'h00});
         rd = dpr;
      end
   endtask

   // Wishbone slave + I2CMB behaviour: ack after one wait cycle, irq 3 cycles after a CMDR write.
   initial begin
      int lat, irq_t, spur_ack;
      logic spur_irq;
      lat = 0; irq_t = 0; spur_ack = 0; spur_irq = 1'b0;
      ack_i = 1'b0; irq_i = 1'b0; dat_i = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            ack_i = 1'b0; irq_i = 1'b0; lat = 0; irq_t = 0; spur_irq = 1'b0;
         end else begin
            if (irq_t > 0) begin
               irq_t--;
               if (irq_t == 0) irq_i = 1'b1;
            end
            if (ack_i) begin
               ack_i = 1'b0;
               if (spur_irq) begin irq_i = 1'b0; spur_irq = 1'b0; end
            end else if (cyc_o && stb_o) begin
               if (lat == 0) lat = 1;
               else begin
                  lat = 0; ack_i = 1'b1;
                  dat_i = (adr_o == 2'd2) ? cur_cmdr : (adr_o == 2'd1) ? cur_dpr : 8'h00;
                  if (adr_o == 2'd2 && we_o && irq_en) irq_t = 3;
                  if (adr_o == 2'd2 && !we_o) irq_i = 1'b0;
               end
            end else if (spur_req != spur_ack) begin
               spur_ack = spur_req;
               ack_i = 1'b1; irq_i = 1'b1; spur_irq = 1'b1;
            end
         end
      end
   end

   // Per-cycle monitor: access order/contents, stability, idle gaps, responses.
   always @(negedge clk) begin
      static logic pcyc = 1'b0, prsp = 1'b0;
      static int gap = 100;
      static logic [10:0] hold = '0;
      static logic [10:0] rhold = '0;
      acc_t e;
      cyc_ctr++;
      if (rst) begin
         pcyc = 1'b0; prsp = 1'b0; gap = 100;
      end else begin
         if (cyc_o || stb_o) chk("stb_eq_cyc", stb_o, cyc_o);
         if (cyc_o && !pcyc) begin
            chk("idle_gap", gap >= 1, 1);
            chk("acc_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("acc_adr", adr_o, e.adr);
               chk("acc_we", we_o, e.we);
               if (e.we) chk("acc_dat", dat_o, e.dat);
            end
            hold = {adr_o, we_o, dat_o};
         end else if (cyc_o) begin
            chk("acc_stable", {adr_o, we_o, dat_o}, hold);
         end
         if (!cyc_o && pcyc) last_fall = cyc_ctr;
         gap = cyc_o ? 0 : gap + 1;
         if (cyc_o || rsp_valid) chk("ready_busy", cmd_ready, 0);
         if (rsp_valid && !prsp) begin
            chk("rsp_expected", exp_rsp_on, 1);
            chk("rsp_status", rsp_status, exp_st);
            chk("rsp_data", rsp_data, exp_rd);
            rhold = {rsp_status, rsp_data};
         end else if (rsp_valid) begin
            chk("rsp_stable", {rsp_status, rsp_data}, rhold);
         end
         pcyc = cyc_o; prsp = rsp_valid;
      end
   end

   task automatic init_seq();
      logic saw, fell;
      saw = 1'b0; fell = 1'b0;
      exp_q.push_back('{2'd0, 1'b1, 8'hC0});
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            chk("ready_only_after_csr_ack", fell, 1);
            break;
         end
         if (cyc_o) saw = 1'b1;
         else if (saw) fell = 1'b1;
      end
      chk("ready_seen_init", cmd_ready, 1);
      chk("csr_acc_left", exp_q.size(), 0);
   endtask

   task automatic issue(input logic [2:0] op, input logic [7:0] d);
      logic got;
      got = cmd_ready;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = cmd_ready;
      end
      chk("ready_seen", got, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [7:0] d, input logic [7:0] cmdr,
                          input logic [7:0] dpr, input logic irq);
      logic [2:0] st;
      logic [7:0] rd;
      logic got;
      int lat;
      model(op, d, cmdr, dpr, irq, st, rd);
      exp_st = st; exp_rd = rd; exp_rsp_on = 1'b1;
      cur_cmdr = cmdr; cur_dpr = dpr; irq_en = irq;
      issue(op, d);
      got = rsp_valid;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         got = rsp_valid;
      end
      chk("rsp_seen", got, 1);
      if (!irq && op != 3'd7) begin
         lat = cyc_ctr - last_fall;
         chk("timeout_latency", (lat >= TO && lat <= TO + 4), 1);
      end
      repeat (2) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      exp_rsp_on = 1'b0;
      chk("rsp_dropped", rsp_valid, 0);
      chk("idle_after_rsp", cmd_ready, 1);
      chk("acc_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      logic [2:0] st;
      logic [7:0] rd;
      logic got;

      // Hand-computed pins on the model itself.
      model(3'd4, 8'h00, 8'h80, 8'h00, 1'b1, st, rd);
      chk("pin_start_n", exp_q.size(), 2);
      chk("pin_start_cmdr", exp_q[0], {2'd2, 1'b1, 8'h04});
      chk("pin_start_st", st, 3'd0);
      chk("pin_start_rd", rd, 8'h00);
      exp_q.delete();
      model(3'd1, 8'hA5, 8'h40, 8'h00, 1'b1, st, rd);
      chk("pin_write_n", exp_q.size(), 3);
      chk("pin_write_dpr", exp_q[0], {2'd1, 1'b1, 8'hA5});
      chk("pin_write_cmdr", exp_q[1], {2'd2, 1'b1, 8'h01});
      chk("pin_write_st", st, 3'd1);
      exp_q.delete();
      model(3'd2, 8'h00, 8'h80, 8'h3C, 1'b1, st, rd);
      chk("pin_rdack_cmdr", exp_q[0], {2'd2, 1'b1, 8'h02});
      chk("pin_rdack_dpr", exp_q[2], {2'd1, 1'b0, 8'h00});
      chk("pin_rdack_rd", rd, 8'h3C);
      exp_q.delete();

      // Outputs while held in reset.
      repeat (3) @(negedge clk);
      chk("rst_bus", {cyc_o, stb_o, we_o, adr_o, dat_o}, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp", {rsp_valid, rsp_status, rsp_data}, 0);

      init_seq();

      run_cmd(3'd4, 8'h00, 8'h80, 8'h00, 1'b1);   // START -> DON
      run_cmd(3'd1, 8'hA5, 8'h40, 8'h00, 1'b1);   // WRITE -> NAK
      run_cmd(3'd2, 8'h00, 8'h80, 8'h3C, 1'b1);   // READ_ACK -> DON, 3C
      run_cmd(3'd3, 8'h00, 8'h40, 8'h77, 1'b1);   // READ_NAK with NAK: no DPR read
      run_cmd(3'd5, 8'h00, 8'h30, 8'h00, 1'b1);   // ERR beats AL
      run_cmd(3'd6, 8'h05, 8'h60, 8'h00, 1'b1);   // AL beats NAK
      run_cmd(3'd0, 8'h0A, 8'h00, 8'h00, 1'b1);   // no status bits -> ERR
      run_cmd(3'd7, 8'h11, 8'h80, 8'h00, 1'b1);   // reserved -> BADOP

      // Stray ack/irq while idle must be ignored.
      spur_req++;
      repeat (4) @(negedge clk);
      chk("spur_no_bus", cyc_o, 0);
      chk("spur_no_rsp", rsp_valid, 0);
      chk("spur_ready", cmd_ready, 1);

      run_cmd(3'd5, 8'h00, 8'h80, 8'h00, 1'b0);   // no irq -> TIMEOUT
      run_cmd(3'd4, 8'h00, 8'h80, 8'h00, 1'b1);   // next command still accepted

      // Reset while the DPR write is on the bus.
      model(3'd1, 8'h5A, 8'h80, 8'h00, 1'b1, st, rd);
      cur_cmdr = 8'h80; irq_en = 1'b1;
      issue(3'd1, 8'h5A);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (cyc_o && adr_o == 2'd1) got = 1'b1;
         else @(negedge clk);
      end
      chk("dpr_access_seen", got, 1);
      @(negedge clk);
      chk("pre_rst_stb", stb_o, 1);
      #1 rst = 1'b1;
      #1;
      chk("async_cyc_drop", cyc_o, 0);
      chk("async_stb_drop", stb_o, 0);
      exp_q.delete();
      exp_rsp_on = 1'b0;
      @(negedge clk);
      chk("rst_mid_rsp", rsp_valid, 0);
      init_seq();
      repeat (5) @(negedge clk);
      chk("no_rsp_after_abort", rsp_valid, 0);

      run_cmd(3'd2, 8'h00, 8'h80, 8'hC3, 1'b1);   // READ_ACK after recovery

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got hang want finish");
      $fatal(1, "watchdog");
   end

endmodule
